// File: rtl/aes_key_expand_pkg.sv
// ---------------------------------------------------------------------------
// aes_key_expand_pkg
//   Shared AES definitions for the key schedule and the cipher datapath:
//   round count, FSM state type, the single S-box table (also used by
//   sub_bytes) and the round-constant lookup.
//   No ports. Optional feature macro used by the key-schedule files:
//   AES_KEY_STORE_EN (round-key store); nothing here depends on it.
// ---------------------------------------------------------------------------
package aes_key_expand_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    // Entry 0 is the leftmost byte, so SBOX[b] is the forward S-box of b.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Round constants for rounds 1..10; other indices are never used.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// ---------------------------------------------------------------------------
// aes_key_expand_if
//   Request / round-key stream bundle for aes_key_expand.
//   master : start, key (and rd_idx) out; busy, rk_valid, rk_idx, rk, done
//            (and rd_key) in.
//   slave  : the mirror image, used by aes_key_expand.
//   AES_KEY_STORE_EN adds rd_idx / rd_key for the round-key store.
// ---------------------------------------------------------------------------
interface aes_key_expand_if;

    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         done;
`ifdef AES_KEY_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    modport master (
        output start, key, rd_idx,
        input  busy, rk_valid, rk_idx, rk, done, rd_key
    );
    modport slave (
        input  start, key, rd_idx,
        output busy, rk_valid, rk_idx, rk, done, rd_key
    );
`else
    modport master (
        output start, key,
        input  busy, rk_valid, rk_idx, rk, done
    );
    modport slave (
        input  start, key,
        output busy, rk_valid, rk_idx, rk, done
    );
`endif

endinterface

// File: rtl/aes_key_expand_sub_word.sv
// ---------------------------------------------------------------------------
// aes_key_expand_sub_word
//   Combinational SubWord: four S-box lookups on a 32-bit word. Any RotWord
//   is applied by the caller on the input wiring.
//   word   in  32  input word
//   result out 32  byte-wise S-box of word
// ---------------------------------------------------------------------------
module aes_key_expand_sub_word
    import aes_key_expand_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] result
);

    assign result = {sbox(word[31:24]), sbox(word[23:16]),
                     sbox(word[15:8]),  sbox(word[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// ---------------------------------------------------------------------------
// aes_key_expand
//   AES-128 iterative key schedule. A start in IDLE samples the key; RK0..RK10
//   then stream out one per clock on rk/rk_idx tagged by rk_valid, with done
//   pulsed alongside RK10. All outputs are registered.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    aes_key_expand_if.slave: start, key -> busy, rk_valid, rk_idx,
//          rk, done (+ rd_idx -> rd_key with AES_KEY_STORE_EN)
//   Macro AES_KEY_STORE_EN: keeps every emitted round key in an 11-entry
//   store readable combinationally through rd_idx/rd_key (0 for rd_idx>10).
// ---------------------------------------------------------------------------
module aes_key_expand
    import aes_key_expand_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = AES_KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_key_expand_if.slave  bus
);

    localparam logic [3:0] LAST = 4'(NR);

    state_t           state;
    logic             busy_q;
    logic             valid_q;
    logic             done_q;
    logic [3:0]       idx_q;
    logic [KEY_W-1:0] rk_q;

    logic [31:0]      w0, w1, w2, w3;
    logic [31:0]      sub_out;
    logic [31:0]      tmp;
    logic [KEY_W-1:0] next_rk;

    assign {w0, w1, w2, w3} = rk_q;

    // RotWord is a pure byte rotation, done here in the wiring.
    aes_key_expand_sub_word u_sub_word (
        .word   ({w3[23:0], w3[31:24]}),
        .result (sub_out)
    );

    // The round being produced is idx_q+1, so that selects the constant.
    assign tmp = sub_out ^ {rcon(idx_q + 4'd1), 24'h0};

    always_comb begin
        next_rk[127:96] = w0 ^ tmp;
        next_rk[95:64]  = w1 ^ next_rk[127:96];
        next_rk[63:32]  = w2 ^ next_rk[95:64];
        next_rk[31:0]   = w3 ^ next_rk[63:32];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values and block order does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 4'd0;
            rk_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rk_q    <= bus.key;
                        idx_q   <= 4'd0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state   <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (idx_q == LAST) begin
                        // RK10 has been shown for its cycle; rk/rk_idx hold it.
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        rk_q  <= next_rk;
                        idx_q <= idx_q + 4'd1;
                        if (idx_q == LAST - 4'd1) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.rk_valid = valid_q;
    assign bus.done     = done_q;
    assign bus.rk_idx   = idx_q;
    assign bus.rk       = rk_q;

`ifdef AES_KEY_STORE_EN
    logic [KEY_W-1:0] store [NR+1];

    // Each entry is written in the same edge that loads the matching key
    // into rk_q, so it becomes readable the cycle that key is emitted.
    // NOTE: the store is reset and cleared explicitly because stale keys
    // from a previous run must read back as zero, not as leftover data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) store[i] <= '0;
        end else if (state == IDLE && bus.start) begin
            for (int i = 0; i <= NR; i++) store[i] <= '0;
            store[0] <= bus.key;
        end else if (state == EXPAND && idx_q != LAST) begin
            store[idx_q + 4'd1] <= next_rk;
        end
    end

    assign bus.rd_key = (bus.rd_idx <= LAST) ? store[bus.rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expand
//   Self-checking bench for aes_key_expand. The reference schedule is built
//   from the AES definitions directly: S-box from GF(2^8) inversion plus the
//   affine map, round constants by repeated doubling, words w[0..43].
//   Honours AES_KEY_STORE_EN for the round-key store checks.
// ---------------------------------------------------------------------------
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_expand_if bus ();

    aes_key_expand dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   sb     [256];
    logic [127:0] ref_rk [11];
    logic [127:0] cap    [11];

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] rk;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic build_ref(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge with the DUT idle. start is raised in cycle t;
    // observation j is taken mid-cycle t+j. inject_at>0 raises start again
    // during cycle t+inject_at with a different key, which must be ignored.
    task automatic run(input logic [127:0] k, input int inject_at,
                       input logic [127:0] inject_key);
        build_ref(k);
        bus.start = 1'b1;
        bus.key   = k;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            bus.start = (j == inject_at);
            bus.key   = (j == inject_at) ? inject_key : rand128();
            check($sformatf("rk_valid t+%0d", j), 128'(bus.rk_valid), 128'(j <= 11));
            check($sformatf("busy t+%0d", j), 128'(bus.busy), 128'(j <= 10));
            check($sformatf("done t+%0d", j), 128'(bus.done), 128'(j == 11));
            if (j <= 11) begin
                cap[j-1] = bus.rk;
                check($sformatf("rk_idx t+%0d", j), 128'(bus.rk_idx), 128'(j - 1));
                check($sformatf("rk t+%0d", j), bus.rk, ref_rk[j-1]);
            end else begin
                check("rk_idx hold", 128'(bus.rk_idx), 128'd10);
                check("rk hold", bus.rk, ref_rk[10]);
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " rk_valid"}, 128'(bus.rk_valid), 128'd0);
        check({tag, " busy"},     128'(bus.busy),     128'd0);
        check({tag, " done"},     128'(bus.done),     128'd0);
        check({tag, " rk_idx"},   128'(bus.rk_idx),   128'd0);
        check({tag, " rk"},       bus.rk,             128'd0);
    endtask

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{KEY_A1, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[1] = '{KEY_A1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[2] = '{128'h0, 1,  128'h62636363626363636263636362636363};
        vecs[3] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        bus.start = 1'b0;
        bus.key   = '0;
`ifdef AES_KEY_STORE_EN
        bus.rd_idx = 4'd0;
`endif
        build_sbox();

        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero_outputs("idle");

        // Known-answer vectors; consecutive runs are back to back.
        foreach (vecs[i]) begin
            run(vecs[i].key, 0, '0);
            check($sformatf("kat%0d rk%0d", i, vecs[i].idx), cap[vecs[i].idx], vecs[i].rk);
        end

        // start mid-run and in the done cycle must both be ignored.
        run(KEY_A1, 5, rand128());
        check("inject t+5 rk10", cap[10], vecs[1].rk);
        run(128'h0, 11, KEY_A1);
        check("inject done rk10", cap[10], vecs[3].rk);
        @(negedge clk);
        check("no restart valid", 128'(bus.rk_valid), 128'd0);

        // Random keys with random (ignored) restarts, some after idle gaps.
        for (int n = 0; n < 8; n++) begin
            int inj = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 11));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run(rand128(), inj, rand128());
        end

        // Asynchronous reset in the middle of a run.
        bus.start = 1'b1;
        bus.key   = rand128();
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1 check_zero_outputs("abort");
        repeat (2) begin
            @(negedge clk);
            check("abort no done", 128'(bus.done), 128'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run(rand128(), 0, '0);

`ifdef AES_KEY_STORE_EN
        run(KEY_A1, 0, '0);
        bus.rd_idx = 4'd0;
        #1 check("store rd0", bus.rd_key, KEY_A1);
        bus.rd_idx = 4'd1;
        #1 check("store rd1", bus.rd_key, vecs[0].rk);
        bus.rd_idx = 4'd10;
        #1 check("store rd10", bus.rd_key, vecs[1].rk);
        bus.rd_idx = 4'd15;
        #1 check("store rd15", bus.rd_key, 128'd0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = 128'h0;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.rd_idx = 4'd10;
        #1 check("store cleared", bus.rd_key, 128'd0);
        repeat (12) @(negedge clk);
        bus.rd_idx = 4'd10;
        #1 check("store zero rk10", bus.rd_key, vecs[3].rk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
